// File: rtl/vrf_bram_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_bram_pkg
//  Description : Shared constants and types for the VRF BRAM read arbiter.
//                RD_LATENCY_HP selects the BRAM output register (2 cycles),
//                RD_LATENCY_LL bypasses it (1 cycle). rd_tag_t is one stage
//                of the read-tracking pipeline. Its id field is sized for the
//                largest supported requester count (8), so a single type
//                serves every NUM_REQ setting.
//  Revision    : 1.0  initial release
// ============================================================================
package vrf_bram_pkg;

    localparam int RD_LATENCY_HP = 2;
    localparam int RD_LATENCY_LL = 1;

    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = $clog2(MAX_REQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/vrf_bram_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_bram_rd_arbiter_if
//  Description : Bundle of the requester handshake, write-port snoop, BRAM
//                read-port controls and the tagged response bus.
//                slave  : the arbiter side
//                master : the requester / BRAM side
//  Ports       : rd_req_*   requester handshake (valid/addr in, ready out)
//                wr_*       BRAM write-port snoop
//                bram_*     BRAM port B controls and read data
//                rd_resp_*  one-hot response strobe and shared data
//                busy_o     at least one read in flight
//  Revision    : 1.0  initial release
// ============================================================================
interface vrf_bram_rd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]                 rd_req_valid_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] rd_req_addr_i;
    logic [NUM_REQ-1:0]                 rd_req_ready_o;
    logic                               wr_en_i;
    logic [ADDR_WIDTH-1:0]              wr_addr_i;
    logic [ADDR_WIDTH-1:0]              bram_addrb_o;
    logic                               bram_enb_o;
    logic                               bram_regceb_o;
    logic                               bram_rstb_o;
    logic [DATA_WIDTH-1:0]              bram_doutb_i;
    logic [NUM_REQ-1:0]                 rd_resp_valid_o;
    logic [DATA_WIDTH-1:0]              rd_resp_data_o;
    logic                               busy_o;

    modport slave (
        input  rd_req_valid_i, rd_req_addr_i, wr_en_i, wr_addr_i, bram_doutb_i,
        output rd_req_ready_o, bram_addrb_o, bram_enb_o, bram_regceb_o,
               bram_rstb_o, rd_resp_valid_o, rd_resp_data_o, busy_o
    );

    modport master (
        output rd_req_valid_i, rd_req_addr_i, wr_en_i, wr_addr_i, bram_doutb_i,
        input  rd_req_ready_o, bram_addrb_o, bram_enb_o, bram_regceb_o,
               bram_rstb_o, rd_resp_valid_o, rd_resp_data_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/vrf_bram_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first set bit
//                of req at or after ptr, wrapping around. Shared with the
//                write-port arbiter.
//  Ports       : req   in  N           request vector
//                ptr   in  $clog2(N)   search start position
//                found out 1           some request is set
//                idx   out $clog2(N)   index of the picked request
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N = 4
) (
    input  wire logic [N-1:0]         req,
    input  wire logic [$clog2(N)-1:0] ptr,
    output logic                      found,
    output logic [$clog2(N)-1:0]      idx
);
    localparam int IDX_W = $clog2(N);

    int pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr) + i) % N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vrf_bram_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_bram_rd_arbiter
//  Description : Shares port B of a simple-dual-port BRAM between NUM_REQ
//                readers. One round-robin grant per cycle drives the BRAM
//                read controls; a {valid,id} pipeline RD_LATENCY deep returns
//                the read data tagged to the requester. A read whose address
//                matches a same-cycle write is held off for that cycle.
//  Ports       : clk   in  clock, rising edge
//                rstn  in  asynchronous active-low reset
//                bus   slave modport of vrf_bram_rd_arbiter_if
//  Revision    : 1.0  initial release
// ============================================================================
module vrf_bram_rd_arbiter
    import vrf_bram_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = RD_LATENCY_HP
) (
    input wire logic               clk,
    input wire logic               rstn,
    vrf_bram_rd_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
            $error("NUM_REQ must be within 2..8");
        end
        if (RD_LATENCY != RD_LATENCY_HP && RD_LATENCY != RD_LATENCY_LL) begin : g_bad_latency
            $error("RD_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      cand;
    logic                  cand_found;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic                  hazard;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  rstb_q;
    logic                  busy;
    logic [DATA_WIDTH-1:0] resp_data;
    rd_tag_t               pipe [RD_LATENCY];
    rd_tag_t               last;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req   (bus.rd_req_valid_i),
        .ptr   (rr_ptr),
        .found (cand_found),
        .idx   (cand)
    );

    // Only the candidate is tested against the write. On a hit the whole
    // cycle is skipped rather than falling through to the next requester,
    // which keeps the grant order strictly round-robin.
    assign cand_addr = bus.rd_req_addr_i[cand];
    assign hazard    = bus.wr_en_i && (bus.wr_addr_i == cand_addr);
    assign grant     = cand_found && !hazard;

    always_comb begin
        bus.rd_req_ready_o = '0;
        if (grant) begin
            bus.rd_req_ready_o[cand] = 1'b1;
        end
    end

    assign bus.bram_enb_o   = grant;
    // The address follows the winner combinationally and parks on the last
    // granted address when idle, so the port does not toggle needlessly.
    assign bus.bram_addrb_o = grant ? cand_addr : addr_hold;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            addr_hold <= '0;
            rstb_q    <= 1'b1;
        end else begin
            rstb_q <= 1'b0;
            if (grant) begin
                addr_hold <= cand_addr;
                rr_ptr    <= (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            end
        end
    end

    // The output-register reset stays asserted for the first clock after
    // reset release so stale BRAM output is flushed before any response.
    assign bus.bram_rstb_o = rstb_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0].valid <= grant;
            pipe[0].id    <= TAG_ID_W'(cand);
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign last = pipe[RD_LATENCY-1];

    generate
        if (RD_LATENCY == RD_LATENCY_HP) begin : g_regce
            // Stage 0 is the cycle the BRAM latch holds the word, so the
            // output register loads exactly then.
            assign bus.bram_regceb_o = pipe[0].valid;
        end else begin : g_no_regce
            assign bus.bram_regceb_o = 1'b0;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
            assign bus.rd_resp_valid_o[i] = last.valid && (last.id == TAG_ID_W'(i));
        end
    endgenerate

    assign resp_data          = bus.bram_doutb_i;
    assign bus.rd_resp_data_o = resp_data;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            busy = busy | pipe[k].valid;
        end
    end
    assign bus.busy_o = busy;

endmodule
`default_nettype wire

// File: tb/tb_vrf_bram_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vrf_bram_rd_arbiter
//  Description : Bench for vrf_bram_rd_arbiter with a behavioural BRAM model.
//                Instance dut uses the output register (latency 2), dut1
//                runs without it (latency 1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vrf_bram_rd_arbiter;
    import vrf_bram_pkg::*;

    localparam int NR = 4;
    localparam int AW = 9;
    localparam int DW = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    vrf_bram_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    vrf_bram_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    vrf_bram_rd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                          .RD_LATENCY(RD_LATENCY_HP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    vrf_bram_rd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                          .RD_LATENCY(RD_LATENCY_LL)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );

    // ---------------- BRAM model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] wr_data;
    logic [DW-1:0] lat_q  = '0;
    logic [DW-1:0] out_q  = '0;
    logic [DW-1:0] lat1_q = '0;

    always @(posedge clk) begin
        if (bus.wr_en_i) mem[bus.wr_addr_i] <= wr_data;
        if (bus.bram_enb_o) lat_q <= mem[bus.bram_addrb_o];
        if (bus.bram_rstb_o) out_q <= '0;
        else if (bus.bram_regceb_o) out_q <= lat_q;
        if (bus1.bram_rstb_o) lat1_q <= '0;
        else if (bus1.bram_enb_o) lat1_q <= mem[bus1.bram_addrb_o];
    end

    assign bus.bram_doutb_i  = out_q;
    assign bus1.bram_doutb_i = lat1_q;

    // ---------------- scoreboard ----------------
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic [NR-1:0] mon_oh;
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.rd_resp_valid_o != '0) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: valid=%b cyc=%0d, none expected",
                             bus.rd_resp_valid_o, cyc);
                end else begin
                    mon_e  = sbq.pop_front();
                    mon_oh = '0;
                    mon_oh[mon_e.id] = 1'b1;
                    if (bus.rd_resp_valid_o !== mon_oh || bus.rd_resp_data_o !== mon_e.data
                        || cyc != mon_e.due) begin
                        failures++;
                        $display("FAIL resp: got valid=%b data=%h cyc=%0d, want valid=%b data=%h cyc=%0d",
                                 bus.rd_resp_valid_o, bus.rd_resp_data_o, cyc,
                                 mon_oh, mon_e.data, mon_e.due);
                    end
                end
            end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL resp_missing: no response at cyc=%0d, want id=%0d data=%h",
                         cyc, sbq[0].id, sbq[0].data);
                void'(sbq.pop_front());
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [DW-1:0] d, input int lat);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.due  = cyc + lat;
        sbq.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.rd_req_valid_i  = '0;
        bus.rd_req_addr_i   = '0;
        bus.wr_en_i         = 1'b0;
        bus.wr_addr_i       = '0;
        bus1.rd_req_valid_i = '0;
        bus1.rd_req_addr_i  = '0;
        bus1.wr_en_i        = 1'b0;
        bus1.wr_addr_i      = '0;
        wr_data             = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        sbq.delete();
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== '0 || bus.bram_enb_o !== 1'b0 || bus.bram_regceb_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b enb=%b regceb=%b, want 0/0/0",
                     bus.rd_req_ready_o, bus.bram_enb_o, bus.bram_regceb_o);
        end
        checks++;
        if (bus.rd_resp_valid_o !== '0 || bus.busy_o !== 1'b0 || bus.bram_addrb_o !== '0) begin
            failures++;
            $display("FAIL reset_state: resp_valid=%b busy=%b addrb=%0d, want 0/0/0",
                     bus.rd_resp_valid_o, bus.busy_o, bus.bram_addrb_o);
        end
        checks++;
        if (bus.bram_rstb_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_rstb: got %b want 1", bus.bram_rstb_o);
        end
        step();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.bram_rstb_o !== 1'b1) begin
            failures++;
            $display("FAIL rstb_before_edge: got %b want 1", bus.bram_rstb_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.bram_rstb_o !== 1'b0) begin
            failures++;
            $display("FAIL rstb_after_edge: got %b want 0", bus.bram_rstb_o);
        end
        step();
    endtask

    task automatic test_single();
        bus.rd_req_valid_i[0] = 1'b1;
        bus.rd_req_addr_i[0]  = AW'(5);
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0001 || bus.bram_enb_o !== 1'b1 || bus.bram_addrb_o !== AW'(5)) begin
            failures++;
            $display("FAIL single_grant: ready=%b enb=%b addrb=%0d, want 0001/1/5",
                     bus.rd_req_ready_o, bus.bram_enb_o, bus.bram_addrb_o);
        end
        push(0, 64'hAA, 2);
        step();
        bus.rd_req_valid_i = '0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.bram_regceb_o !== 1'b1) begin
            failures++;
            $display("FAIL single_busy1: busy=%b regceb=%b, want 1/1", bus.busy_o, bus.bram_regceb_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL single_busy2: busy=%b want 1", bus.busy_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.bram_enb_o !== 1'b0 || bus.bram_addrb_o !== AW'(5)) begin
            failures++;
            $display("FAIL single_idle: busy=%b enb=%b addrb=%0d, want 0/0/5",
                     bus.busy_o, bus.bram_enb_o, bus.bram_addrb_o);
        end
        step();
    endtask

    task automatic test_round_robin();
        int exp_id;
        logic [NR-1:0] oh;
        for (int r = 0; r < NR; r++) bus.rd_req_addr_i[r] = AW'(10 + r);
        bus.rd_req_valid_i = '1;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % NR;
            oh = '0;
            oh[exp_id] = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.rd_req_ready_o !== oh || bus.bram_addrb_o !== AW'(10 + exp_id)) begin
                failures++;
                $display("FAIL rr_grant%0d: ready=%b addrb=%0d, want %b/%0d",
                         k, bus.rd_req_ready_o, bus.bram_addrb_o, oh, 10 + exp_id);
            end
            push(exp_id, mem[10 + exp_id], 2);
            step();
            if (exp_id != 0) bus.rd_req_valid_i[exp_id] = 1'b0;
        end
        bus.rd_req_valid_i = '0;
        repeat (3) step();
    endtask

    // rr_ptr is 1 here; if the hazard wrongly advanced it, req 0 would win at T+1.
    task automatic test_hazard_same();
        bus.rd_req_valid_i[1] = 1'b1;
        bus.rd_req_addr_i[1]  = AW'(7);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = AW'(7);
        wr_data       = 64'h55;
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== '0 || bus.bram_enb_o !== 1'b0 || bus.bram_addrb_o !== AW'(10)) begin
            failures++;
            $display("FAIL hazard_block: ready=%b enb=%b addrb=%0d, want 0000/0/10",
                     bus.rd_req_ready_o, bus.bram_enb_o, bus.bram_addrb_o);
        end
        step();
        bus.wr_en_i = 1'b0;
        bus.rd_req_valid_i[0] = 1'b1;
        bus.rd_req_addr_i[0]  = AW'(20);
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0010) begin
            failures++;
            $display("FAIL hazard_retry: ready=%b want 0010", bus.rd_req_ready_o);
        end
        push(1, 64'h55, 2);
        step();
        bus.rd_req_valid_i[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0001) begin
            failures++;
            $display("FAIL hazard_next: ready=%b want 0001", bus.rd_req_ready_o);
        end
        push(0, mem[20], 2);
        step();
        bus.rd_req_valid_i = '0;
        repeat (3) step();
    endtask

    task automatic test_prev_write();
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = AW'(30);
        wr_data       = 64'h77;
        step();
        bus.wr_addr_i = AW'(31);
        wr_data       = 64'h31;
        bus.rd_req_valid_i[2] = 1'b1;
        bus.rd_req_addr_i[2]  = AW'(30);
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0100) begin
            failures++;
            $display("FAIL prev_write_grant: ready=%b want 0100", bus.rd_req_ready_o);
        end
        push(2, 64'h77, 2);
        step();
        bus.wr_en_i = 1'b0;
        bus.rd_req_valid_i = '0;
        repeat (3) step();
    endtask

    task automatic test_hazard_other();
        do_reset();
        bus.rd_req_valid_i[2] = 1'b1;
        bus.rd_req_addr_i[2]  = AW'(40);
        bus.rd_req_valid_i[3] = 1'b1;
        bus.rd_req_addr_i[3]  = AW'(41);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = AW'(40);
        wr_data       = 64'h99;
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== '0 || bus.bram_enb_o !== 1'b0) begin
            failures++;
            $display("FAIL hazard_other_block: ready=%b enb=%b, want 0000/0",
                     bus.rd_req_ready_o, bus.bram_enb_o);
        end
        step();
        bus.wr_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0100) begin
            failures++;
            $display("FAIL hazard_other_r2: ready=%b want 0100", bus.rd_req_ready_o);
        end
        push(2, 64'h99, 2);
        step();
        bus.rd_req_valid_i[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b1000) begin
            failures++;
            $display("FAIL hazard_other_r3: ready=%b want 1000", bus.rd_req_ready_o);
        end
        push(3, mem[41], 2);
        step();
        bus.rd_req_valid_i = '0;
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        bus.rd_req_valid_i[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.rd_req_addr_i[3] = AW'(60 + k);
            @(negedge clk);
            checks++;
            if (bus.rd_req_ready_o !== 4'b1000 || bus.bram_addrb_o !== AW'(60 + k)) begin
                failures++;
                $display("FAIL b2b_grant%0d: ready=%b addrb=%0d, want 1000/%0d",
                         k, bus.rd_req_ready_o, bus.bram_addrb_o, 60 + k);
            end
            push(3, mem[60 + k], 2);
            step();
        end
        bus.rd_req_valid_i = '0;
        repeat (3) step();
    endtask

    task automatic test_lat1();
        bus1.rd_req_valid_i[0] = 1'b1;
        bus1.rd_req_addr_i[0]  = AW'(5);
        @(negedge clk);
        checks++;
        if (bus1.rd_req_ready_o !== 4'b0001 || bus1.bram_regceb_o !== 1'b0) begin
            failures++;
            $display("FAIL lat1_grant: ready=%b regceb=%b, want 0001/0",
                     bus1.rd_req_ready_o, bus1.bram_regceb_o);
        end
        step();
        bus1.rd_req_valid_i = '0;
        @(negedge clk);
        checks++;
        if (bus1.rd_resp_valid_o !== 4'b0001 || bus1.rd_resp_data_o !== 64'hAA
            || bus1.bram_regceb_o !== 1'b0) begin
            failures++;
            $display("FAIL lat1_resp: valid=%b data=%h regceb=%b, want 0001/aa/0",
                     bus1.rd_resp_valid_o, bus1.rd_resp_data_o, bus1.bram_regceb_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus1.rd_resp_valid_o !== '0 || bus1.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL lat1_done: valid=%b busy=%b, want 0000/0",
                     bus1.rd_resp_valid_o, bus1.busy_o);
        end
        step();
    endtask

    task automatic test_reset_inflight();
        bus.rd_req_valid_i[0] = 1'b1;
        bus.rd_req_addr_i[0]  = AW'(50);
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0001) begin
            failures++;
            $display("FAIL flush_g0: ready=%b want 0001", bus.rd_req_ready_o);
        end
        step();
        bus.rd_req_valid_i    = '0;
        bus.rd_req_valid_i[1] = 1'b1;
        bus.rd_req_addr_i[1]  = AW'(51);
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0010) begin
            failures++;
            $display("FAIL flush_g1: ready=%b want 0010", bus.rd_req_ready_o);
        end
        step();
        clear_inputs();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rd_resp_valid_o !== '0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_low: valid=%b busy=%b, want 0000/0",
                     bus.rd_resp_valid_o, bus.busy_o);
        end
        step();
        step();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.bram_rstb_o !== 1'b1 || bus.rd_resp_valid_o !== '0) begin
            failures++;
            $display("FAIL flush_rel: rstb=%b valid=%b, want 1/0000",
                     bus.bram_rstb_o, bus.rd_resp_valid_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.bram_rstb_o !== 1'b0 || bus.rd_resp_valid_o !== '0) begin
            failures++;
            $display("FAIL flush_post: rstb=%b valid=%b, want 0/0000",
                     bus.bram_rstb_o, bus.rd_resp_valid_o);
        end
        step();
        for (int r = 0; r < NR; r++) bus.rd_req_addr_i[r] = AW'(70 + r);
        bus.rd_req_valid_i = '1;
        @(negedge clk);
        checks++;
        if (bus.rd_req_ready_o !== 4'b0001) begin
            failures++;
            $display("FAIL flush_ptr: ready=%b want 0001", bus.rd_req_ready_o);
        end
        push(0, mem[70], 2);
        step();
        bus.rd_req_valid_i = '0;
        repeat (3) step();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = 64'hD000_0000_0000_0000 | 64'(a);
        mem[5] = 64'hAA;
        mem[7] = 64'h11;
        clear_inputs();

        test_reset();
        test_single();
        do_reset();
        test_round_robin();
        test_hazard_same();
        test_prev_write();
        test_hazard_other();
        test_back_to_back();
        test_lat1();
        test_reset_inflight();

        repeat (4) step();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding, want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
